ring_buffer_fetch_ctrl: RTL and testbench

- Sequences the read side of the packet ring buffer. Accepts one DMA descriptor at a time (start, base, size, queue), issues flit reads into the ring buffer's 2-cycle-latency BRAM port, and handles wrap-around at the slot limit.
- Forwards the returned flits through a small credit-protected output FIFO to the PCIe/DMA writer, which can apply backpressure.
- Pulses dma_done back to the ring buffer once the last flit of the descriptor is accepted downstream.

---
 rtl/ring_buffer_fetch_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_ring_buffer_fetch_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_buffer_fetch_ctrl.sv
// Read-side sequencer for the packet ring buffer: walks one DMA descriptor through
// the 2-cycle BRAM port with wrap at WRAP_SLOT and feeds a credit-protected output FIFO.
module ring_buffer_fetch_ctrl #(
    parameter int PDU_DEPTH      = 512,
    parameter int PDU_AWIDTH     = $clog2(PDU_DEPTH),
    parameter int WRAP_SLOT      = 448,
    parameter int APP_IDX_WIDTH  = 9,
    parameter int OUT_FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     dma_start,
    input  logic [PDU_AWIDTH-1:0]    dma_size,
    input  logic [PDU_AWIDTH-1:0]    dma_base_addr,
    input  logic [APP_IDX_WIDTH-1:0] dma_queue,
    output logic                     dma_done,
    output logic                     rd_en,
    output logic [PDU_AWIDTH-1:0]    rd_addr,
    input  logic                     rd_valid,
    input  logic [511:0]             rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [511:0]             out_data,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [APP_IDX_WIDTH-1:0] out_queue,
    output logic                     busy,
    output logic                     start_err
);

    localparam int FIFO_AW = $clog2(OUT_FIFO_DEPTH);
    localparam int CNT_W   = FIFO_AW + 1;

    // Output handshake: a flit moves on a cycle where out_valid && out_ready; while
    // out_valid is high and out_ready low, out_data/sop/eop/queue do not change.

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [PDU_AWIDTH-1:0]    cur_addr_q, cur_addr_d;
    logic [PDU_AWIDTH-1:0]    rem_rd_q, rem_rd_d;
    logic [PDU_AWIDTH-1:0]    rem_out_q, rem_out_d;
    logic [PDU_AWIDTH-1:0]    size_q, size_d;
    logic [APP_IDX_WIDTH-1:0] queue_q, queue_d;
    logic [1:0]               inflight_q, inflight_d;
    logic [CNT_W-1:0]         fifo_cnt_q, fifo_cnt_d;
    logic [FIFO_AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic                     dma_done_q, dma_done_d;
    logic                     start_err_q, start_err_d;
    logic [511:0]             fifo_mem [OUT_FIFO_DEPTH];

    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [CNT_W:0]        credit_used;
    logic [PDU_AWIDTH:0]   next_addr;

    // Reads in flight plus queued flits may never exceed the FIFO, so a read can
    // always land even if downstream stalls for ever.
    assign credit_used = {1'b0, fifo_cnt_q} + {{(CNT_W-1){1'b0}}, inflight_q};
    assign issue       = (state_q == FETCH) && (rem_rd_q != '0)
                         && (credit_used < (CNT_W+1)'(OUT_FIFO_DEPTH));
    // Returns with nothing outstanding are stale reads from before a reset.
    assign push        = rd_valid && (inflight_q != 2'd0);
    assign out_valid   = (fifo_cnt_q != '0);
    assign pop         = out_valid && out_ready;
    assign next_addr   = {1'b0, cur_addr_q} + (PDU_AWIDTH+1)'(1);

    assign rd_en     = issue;
    assign rd_addr   = cur_addr_q;
    assign busy      = (state_q != IDLE);
    assign dma_done  = dma_done_q;
    assign start_err = start_err_q;
    assign out_queue = queue_q;
    assign out_data  = out_valid ? fifo_mem[rd_ptr_q] : '0;
    assign out_sop   = out_valid && (rem_out_q == size_q);
    assign out_eop   = out_valid && (rem_out_q == PDU_AWIDTH'(1));

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        rem_rd_d    = rem_rd_q;
        rem_out_d   = rem_out_q;
        size_d      = size_q;
        queue_d     = queue_q;
        dma_done_d  = 1'b0;
        start_err_d = start_err_q;

        if (pop) begin
            rem_out_d = rem_out_q - PDU_AWIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (dma_start) begin
                    if (dma_size != '0) begin
                        state_d    = FETCH;
                        cur_addr_d = dma_base_addr;
                        rem_rd_d   = dma_size;
                        rem_out_d  = dma_size;
                        size_d     = dma_size;
                        queue_d    = dma_queue;
                    end else begin
                        dma_done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (issue) begin
                    if (next_addr >= (PDU_AWIDTH+1)'(WRAP_SLOT)) begin
                        cur_addr_d = '0;
                    end else begin
                        cur_addr_d = next_addr[PDU_AWIDTH-1:0];
                    end
                    rem_rd_d = rem_rd_q - PDU_AWIDTH'(1);
                    if (rem_rd_q == PDU_AWIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (rem_out_q == '0) begin
                    dma_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (dma_start && (state_q != IDLE)) begin
            start_err_d = 1'b1;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        fifo_cnt_d = fifo_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        case ({issue, push})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase

        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            rem_rd_q    <= '0;
            rem_out_q   <= '0;
            size_q      <= '0;
            queue_q     <= '0;
            inflight_q  <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            dma_done_q  <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            rem_rd_q    <= rem_rd_d;
            rem_out_q   <= rem_out_d;
            size_q      <= size_d;
            queue_q     <= queue_d;
            inflight_q  <= inflight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            dma_done_q  <= dma_done_d;
            start_err_q <= start_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && (fifo_cnt_q == CNT_W'(OUT_FIFO_DEPTH))));
        end
    end

endmodule

// File: tb/tb_ring_buffer_fetch_ctrl.sv
// Bench for ring_buffer_fetch_ctrl: BRAM model, directed descriptors, then random
// descriptors under random backpressure, checked against a flit/address scoreboard.
module tb_ring_buffer_fetch_ctrl;

    localparam int AW   = 9;
    localparam int QW   = 9;
    localparam int WRAP = 448;
    localparam int W    = 512 + 2 + QW;

    logic           clk;
    logic           rst_n;
    logic           dma_start;
    logic [AW-1:0]  dma_size;
    logic [AW-1:0]  dma_base_addr;
    logic [QW-1:0]  dma_queue;
    logic           dma_done;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic           rd_valid;
    logic [511:0]   rd_data;
    logic           out_valid;
    logic           out_ready;
    logic [511:0]   out_data;
    logic           out_sop;
    logic           out_eop;
    logic [QW-1:0]  out_queue;
    logic           busy;
    logic           start_err;

    ring_buffer_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .dma_start(dma_start), .dma_size(dma_size), .dma_base_addr(dma_base_addr),
        .dma_queue(dma_queue), .dma_done(dma_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_queue(out_queue),
        .busy(busy), .start_err(start_err)
    );

    logic [W-1:0]   exp_q[$];
    logic [AW-1:0]  exp_addr_q[$];
    logic [511:0]   ram [512];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_rd = 0;
    int n_done = 0;
    int last_rd_cyc = 0;
    int first_rd_cyc = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int ready_mode = 1;
    bit first_pending = 0;
    bit in_reset = 1;
    bit prev_stall = 0;
    logic [W-1:0] prev_obs;

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // BRAM port model: data appears 2 cycles after rd_en
    initial begin
        logic          p1v, p2v;
        logic [AW-1:0] p1a, p2a;
        p1v = 0; p2v = 0; p1a = '0; p2a = '0;
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk);
            rd_valid = p2v;
            rd_data  = p2v ? ram[p2a] : '0;
            p2v = p1v; p2a = p1a;
            p1v = rd_en; p1a = rd_addr;
        end
    end

    // Downstream ready: 0 = hold low, 1 = hold high, 2 = random
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
            else                 out_ready = (ready_mode == 1);
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] obs;
        logic [W-1:0] exp_flit;
        logic [AW-1:0] exp_a;
        obs = {out_data, out_sop, out_eop, out_queue};
        if (in_reset) begin
            prev_stall = 0;
        end else begin
            if (rd_en) begin
                n_rd++;
                last_rd_cyc = cyc;
                if (first_pending) begin
                    first_rd_cyc  = cyc;
                    first_pending = 0;
                end
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_addr: unexpected read at %0d", rd_addr);
                end else begin
                    exp_a = exp_addr_q.pop_front();
                    if (rd_addr !== exp_a) begin
                        errors++;
                        $display("FAIL rd_addr: got %0d expected %0d", rd_addr, exp_a);
                    end
                end
            end
            if (dma_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (prev_stall) begin
                checks++;
                if (!out_valid || obs !== prev_obs) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0d obs=%h expected %h", out_valid, obs, prev_obs);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL flit: unexpected flit sop=%0d eop=%0d q=%0d", out_sop, out_eop, out_queue);
                end else begin
                    exp_flit = exp_q.pop_front();
                    if (obs !== exp_flit) begin
                        errors++;
                        $display("FAIL flit: got sop=%0d eop=%0d q=%0d d=%h expected sop=%0d eop=%0d q=%0d d=%h",
                                 out_sop, out_eop, out_queue, out_data[63:0],
                                 exp_flit[QW+1], exp_flit[QW], exp_flit[QW-1:0], exp_flit[W-1 -: 64]);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_obs   = obs;
        end
    end

    // Driver tasks
    task automatic push_desc(input int base, input int size, input int q);
        for (int i = 0; i < size; i++) begin
            int a;
            a = (base + i) % WRAP;
            exp_addr_q.push_back(AW'(a));
            exp_q.push_back({ram[a], (i == 0), (i == size - 1), QW'(q)});
        end
    endtask

    task automatic do_start(input int base, input int size, input int q, input bit accept);
        @(negedge clk);
        dma_start     = 1'b1;
        dma_base_addr = AW'(base);
        dma_size      = AW'(size);
        dma_queue     = QW'(q);
        start_cyc     = cyc;
        if (accept) begin
            push_desc(base, size, q);
            first_pending = 1;
        end
        @(negedge clk);
        dma_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int k;
        k = 0;
        while (n_done == d0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("done_seen", 64'(n_done > d0), 1);
        repeat (3) @(posedge clk);
        chk("done_single", 64'(n_done), 64'(d0 + 1));
        chk("drained", 64'(exp_q.size() + exp_addr_q.size()), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rd_en"},     64'(rd_en), 0);
        chk({tag, "_rd_addr"},   64'(rd_addr), 0);
        chk({tag, "_dma_done"},  64'(dma_done), 0);
        chk({tag, "_out_valid"}, 64'(out_valid), 0);
        chk({tag, "_out_sop"},   64'(out_sop), 0);
        chk({tag, "_out_eop"},   64'(out_eop), 0);
        chk({tag, "_out_queue"}, 64'(out_queue), 0);
        chk({tag, "_out_data"},  64'(|out_data), 0);
        chk({tag, "_busy"},      64'(busy), 0);
        chk({tag, "_start_err"}, 64'(start_err), 0);
    endtask

    initial begin
        int d0, n0, k, seen_valid;
        for (int i = 0; i < 512; i++) begin
            for (int j = 0; j < 16; j++) ram[i][j*32 +: 32] = $urandom();
        end
        rst_n = 1'b0;
        dma_start = 1'b0; dma_size = '0; dma_base_addr = '0; dma_queue = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        in_reset = 0;
        repeat (2) @(negedge clk);

        // Basic descriptor with timing
        ready_mode = 1;
        d0 = n_done;
        do_start(10, 3, 5, 1);
        chk("busy_after_start", 64'(busy), 1);
        wait_done(d0, 200);
        chk("first_rd_latency", 64'(first_rd_cyc - start_cyc), 1);
        chk("done_after_last_rd", 64'(done_cyc - last_rd_cyc), 5);
        chk("busy_after_done", 64'(busy), 0);

        // Wrap at slot limit
        d0 = n_done;
        do_start(446, 4, 7, 1);
        wait_done(d0, 200);

        // Backpressure: reads stop at FIFO credit
        ready_mode = 0;
        d0 = n_done;
        n0 = n_rd;
        do_start(0, 8, 3, 1);
        repeat (20) @(negedge clk);
        chk("stall_reads", 64'(n_rd - n0), 4);
        chk("stall_valid", 64'(out_valid), 1);
        ready_mode = 1;
        wait_done(d0, 300);

        // Zero-size descriptor
        d0 = n_done;
        n0 = n_rd;
        do_start(30, 0, 2, 0);
        chk("zero_busy", 64'(busy), 0);
        wait_done(d0, 20);
        chk("zero_done_latency", 64'(done_cyc - start_cyc), 1);
        chk("zero_no_reads", 64'(n_rd - n0), 0);

        // Start while busy is ignored and flagged
        d0 = n_done;
        do_start(200, 6, 11, 1);
        @(negedge clk);
        do_start(300, 3, 12, 0);
        chk("start_err_set", 64'(start_err), 1);
        wait_done(d0, 300);
        d0 = n_done;
        do_start(50, 5, 13, 1);
        wait_done(d0, 300);
        chk("start_err_sticky", 64'(start_err), 1);

        // Reset mid-fetch with reads in flight
        n0 = n_rd;
        do_start(20, 10, 4, 1);
        k = 0;
        while (n_rd - n0 < 3 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("reset_prefetch_reads", 64'(n_rd - n0 >= 3), 1);
        @(posedge clk);
        #1;
        in_reset = 1;
        rst_n = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("midreset");
        rst_n = 1'b1;
        in_reset = 0;
        seen_valid = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        chk("stale_returns_dropped", 64'(seen_valid), 0);
        d0 = n_done;
        do_start(100, 2, 9, 1);
        wait_done(d0, 200);

        // Random descriptors under random backpressure
        for (int t = 0; t < 25; t++) begin
            int base, size, q;
            base = $urandom_range(0, WRAP - 1);
            size = $urandom_range(1, 40);
            q    = $urandom_range(0, 511);
            ready_mode = (t % 4 == 0) ? 1 : 2;
            d0 = n_done;
            do_start(base, size, q, 1);
            wait_done(d0, 2000);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        ready_mode = 1;
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
